// File: rtl/cache_mem_ctrl_if.sv
// Cache-side line request/response and word-wide memory bus of cache_mem_ctrl.
// The slave modport is the controller; the master modport is its environment (cache plus memory).
interface cache_mem_ctrl_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4
);
  localparam int LINE_W = DATA_WIDTH * WORDS_PER_LINE;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LINE_W-1:0]     req_line;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [LINE_W-1:0]     rsp_line;
  logic                  rsp_err;
  logic                  mem_valid;
  logic                  mem_ready;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_line, rsp_ready,
           mem_ready, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_line, rsp_err,
           mem_valid, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_line, rsp_ready,
           mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_line, rsp_err,
           mem_valid, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_mem_ctrl.sv
// Serialises one cache line fill/write-back into per-word memory transactions.
// Define MEMCTRL_TIMEOUT_EN to abort a stalled word after TIMEOUT_CYCLES and flag rsp_err.
module cache_mem_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic             clk,
  input logic             reset,
  cache_mem_ctrl_if.slave bus
);
  localparam int CW         = $clog2(WORDS_PER_LINE);
  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int BW         = $clog2(BYTES);
  localparam int LINE_BYTES = WORDS_PER_LINE * BYTES;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_BYTES - 1);

  if (TIMEOUT_CYCLES < 1 || WORDS_PER_LINE < 2 || (WORDS_PER_LINE & (WORDS_PER_LINE - 1)) != 0)
  begin : g_bad_param
    $error("cache_mem_ctrl: illegal TIMEOUT_CYCLES or WORDS_PER_LINE");
  end

  typedef enum logic [1:0] {IDLE, ADDR, RDATA, RESP} state_e;
  typedef logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] line_t;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  wr_q, wr_d;
  line_t                 line_q, line_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last;

  assign last = (cnt_q == CW'(WORDS_PER_LINE - 1));

`ifdef MEMCTRL_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SW-1:0] stall_q, stall_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    wr_d    = wr_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
`ifdef MEMCTRL_TIMEOUT_EN
    err_d   = err_q;
    stall_d = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          base_d  = bus.req_addr & ~OFF_MASK;
          wr_d    = bus.req_write;
          // Fills start from zero so a timed-out line reports unreceived words as 0.
          line_d  = bus.req_write ? line_t'(bus.req_line) : '0;
          cnt_d   = '0;
          state_d = ADDR;
`ifdef MEMCTRL_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ADDR: begin
        if (bus.mem_ready) begin
          if (!wr_q)     state_d = RDATA;
          else if (last) state_d = RESP;
          else           cnt_d   = cnt_q + 1'b1;
        end
      end
      RDATA: begin
        if (bus.mem_rvalid) begin
          line_d[cnt_q] = bus.mem_rdata;
          if (last) begin
            state_d = RESP;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ADDR;
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
`ifdef MEMCTRL_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef MEMCTRL_TIMEOUT_EN
    if ((state_q == ADDR && !bus.mem_ready) || (state_q == RDATA && !bus.mem_rvalid)) begin
      if (stall_q == SW'(TIMEOUT_CYCLES - 1)) begin
        state_d = RESP;
        err_d   = 1'b1;
      end else begin
        stall_d = stall_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      wr_q    <= 1'b0;
      line_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      wr_q    <= wr_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MEMCTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_valid = (state_q == ADDR);
  assign bus.mem_write = (state_q == ADDR) && wr_q;
  assign bus.mem_addr  = base_q + (ADDR_WIDTH'(cnt_q) << BW);
  assign bus.mem_wdata = line_q[cnt_q];
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_line  = line_q;
endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Scoreboard bench for cache_mem_ctrl: a driver pushes expected word transactions and line
// responses from a memory-image model, a monitor pops and compares them as the DUT presents them.
module tb_cache_mem_ctrl;
  localparam int AW = 32, DW = 32, WPL = 4, LW = DW * WPL;

  typedef struct {logic [AW-1:0] addr; logic wr; logic [DW-1:0] wdata;} word_t;
  typedef struct {logic [LW-1:0] line; logic err; int nw; int lat;} rsp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_mem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(WPL)) bus ();

  cache_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(WPL), .TIMEOUT_CYCLES(8))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0, n_pass = 0;
  int ecnt = 0, acc_cnt = 0, req_hs_n = 0, rsp_hs_n = 0;
  int rdy_max = 0, rv_max = 0, hold_left = 0;
  bit stall_all = 1'b0;
  word_t wq[$];
  rsp_t  rq[$];
  int    hs_q[$];
  logic [DW-1:0] mem_img [bit [AW-1:0]];
  logic [DW-1:0] ref_img [bit [AW-1:0]];

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: event occurred, required none", name);
  endtask

  task automatic set_word(input logic [AW-1:0] a, input logic [DW-1:0] v);
    mem_img[a] = v;
    ref_img[a] = v;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < WPL; i++) l[i*DW +: DW] = $urandom;
    return l;
  endfunction

  // Reference model: a line is WPL consecutive words of the memory image starting at the aligned base.
  task automatic do_req(input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] line,
                        input int lat, input bit expect_to);
    rsp_t r;
    word_t w;
    int t;
    logic [AW-1:0] base;
    base = addr & ~AW'(WPL * DW / 8 - 1);
    r.line = '0; r.err = expect_to; r.lat = lat; r.nw = expect_to ? 0 : WPL;
    if (!expect_to) begin
      for (int i = 0; i < WPL; i++) begin
        w.addr = base + AW'(i * DW / 8); w.wr = wr; w.wdata = line[i*DW +: DW];
        wq.push_back(w);
        if (wr) begin
          ref_img[w.addr] = w.wdata;
          r.line[i*DW +: DW] = w.wdata;
        end else begin
          r.line[i*DW +: DW] = ref_img.exists(w.addr) ? ref_img[w.addr] : '0;
        end
      end
    end
    rq.push_back(r);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_line = line;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.req_ready) break;
      if (++t > 2000) begin fail("req_accept_timeout"); $fatal(1, "request never accepted"); end
    end
    @(posedge clk); #1;
    hs_q.push_back(ecnt);
    chk("one_request_at_a_time", LW'(req_hs_n - rsp_hs_n), '0);
    req_hs_n++;
    bus.req_valid = 1'b0; bus.req_write = $urandom_range(1, 0); bus.req_line = rand_line();
  endtask

  task automatic wait_idle();
    int t = 0;
    while (req_hs_n != rsp_hs_n || rq.size() != 0) begin
      @(negedge clk);
      if (++t > 3000) begin fail("idle_timeout"); $fatal(1, "response never arrived"); end
    end
    @(posedge clk); #1;
  endtask

  // Memory device: honours mem_ready stalls and returns read data rdelay cycles after accept.
  initial begin : memory
    bit acc, pend, cwr;
    int rwait, rdy_wait;
    logic [AW-1:0] raddr, caddr;
    logic [DW-1:0] cwd;
    pend = 0; rwait = 0; rdy_wait = 0;
    bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      acc = reset && bus.mem_valid && bus.mem_ready;
      caddr = bus.mem_addr; cwr = bus.mem_write; cwd = bus.mem_wdata;
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
      if (!reset) begin
        pend = 0; rdy_wait = 0;
        bus.mem_ready = !stall_all;
        continue;
      end
      if (acc) begin
        if (cwr) mem_img[caddr] = cwd;
        else begin pend = 1; raddr = caddr; rwait = $urandom_range(rv_max, 0); end
        rdy_wait = $urandom_range(rdy_max, 0);
      end else if (bus.mem_valid && rdy_wait > 0) begin
        rdy_wait--;
      end
      bus.mem_ready = !stall_all && (rdy_wait == 0);
      if (pend) begin
        if (rwait == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = mem_img.exists(raddr) ? mem_img[raddr] : '0;
          pend = 0;
        end else begin
          rwait--;
        end
      end
    end
  end

  initial begin : rsp_drv
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bus.rsp_valid && hold_left > 0) begin
        bus.rsp_ready = 1'b0;
        hold_left--;
      end else begin
        bus.rsp_ready = 1'b1;
      end
    end
  end

  initial begin : monitor
    logic pv_mv, pv_mr, pv_wr, pv_rv, pv_rr, pv_err, hs_prev;
    logic [AW-1:0] pv_addr;
    logic [DW-1:0] pv_wd;
    logic [LW-1:0] pv_line;
    int rise_edge, nacc, h;
    word_t w;
    rsp_t r;
    pv_mv = 0; pv_mr = 0; pv_wr = 0; pv_rv = 0; pv_rr = 0; pv_err = 0; hs_prev = 0;
    pv_addr = '0; pv_wd = '0; pv_line = '0; rise_edge = 0; nacc = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pv_mv = 0; pv_rv = 0; hs_prev = 0; nacc = 0;
        continue;
      end
      if (pv_mv && !pv_mr && !bus.rsp_valid)
        chk("mem_stable_while_stalled", {bus.mem_valid, bus.mem_write, bus.mem_addr, bus.mem_wdata},
            {1'b1, pv_wr, pv_addr, pv_wd});
      if (pv_rv && !pv_rr)
        chk("rsp_stable_while_held", {bus.rsp_valid, bus.rsp_err, bus.rsp_line}, {1'b1, pv_err, pv_line});
      if (hs_prev) chk("req_ready_after_rsp", bus.req_ready, 1);
      hs_prev = 0;
      if (bus.mem_valid && bus.mem_ready) begin
        acc_cnt++; nacc++;
        if (wq.size() == 0) fail("unexpected_mem_word");
        else begin
          w = wq.pop_front();
          chk("mem_addr", bus.mem_addr, w.addr);
          chk("mem_write", bus.mem_write, w.wr);
          if (w.wr) chk("mem_wdata", bus.mem_wdata, w.wdata);
        end
      end
      if (bus.rsp_valid && !pv_rv) begin
        rise_edge = ecnt;
        chk("mem_valid_in_resp", bus.mem_valid, 0);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_hs_n++; hs_prev = 1;
        if (rq.size() == 0 || hs_q.size() == 0) fail("unexpected_rsp");
        else begin
          r = rq.pop_front();
          h = hs_q.pop_front();
          chk("rsp_line", bus.rsp_line, r.line);
          chk("rsp_err", bus.rsp_err, r.err);
          chk("words_per_transfer", LW'(nacc), LW'(r.nw));
          if (r.lat > 0) chk("rsp_latency", LW'(rise_edge - h + 1), LW'(r.lat));
        end
        nacc = 0;
      end
      pv_mv = bus.mem_valid; pv_mr = bus.mem_ready; pv_wr = bus.mem_write;
      pv_addr = bus.mem_addr; pv_wd = bus.mem_wdata;
      pv_rv = bus.rsp_valid; pv_rr = bus.rsp_ready; pv_err = bus.rsp_err; pv_line = bus.rsp_line;
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_err",   bus.rsp_err,   0);
    chk("rst_rsp_line",  bus.rsp_line,  0);
    chk("rst_mem_valid", bus.mem_valid, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_addr",  bus.mem_addr,  0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
  endtask

  initial begin : main
    logic [AW-1:0] bases [5];
    logic [AW-1:0] a;
    int target, t;
    bases = '{32'h0000_1000, 32'h0000_2010, 32'h0000_3000, 32'h0000_5040, 32'hFFFF_FFC0};
    reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_line = '0;
    for (int b = 0; b < 5; b++)
      for (int i = 0; i < WPL; i++) set_word(bases[b] + AW'(4 * i), $urandom);
    for (int i = 0; i < WPL; i++) set_word(32'h1000 + AW'(4 * i), 32'hA0 + DW'(i));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    do_req(1'b0, 32'h1000, '0, 2 * WPL + 1, 1'b0);
    wait_idle();
    do_req(1'b1, 32'h2017, {32'h44, 32'h33, 32'h22, 32'h11}, WPL + 1, 1'b0);
    wait_idle();

    hold_left = 3;
    do_req(1'b0, 32'h1000, '0, 2 * WPL + 1, 1'b0);
    do_req(1'b1, 32'h4000, rand_line(), WPL + 1, 1'b0);
    wait_idle();
    do_req(1'b0, 32'h2010, '0, 2 * WPL + 1, 1'b0);
    wait_idle();

    rdy_max = 5; rv_max = 5;
    for (int i = 0; i < 24; i++) begin
      a = bases[$urandom_range(4, 0)] | AW'($urandom_range(15, 0));
      hold_left = $urandom_range(2, 0);
      do_req(1'(($urandom_range(1, 0))), a, rand_line(), 0, 1'b0);
      if ($urandom_range(1, 0) == 1) wait_idle();
    end
    wait_idle();

    // Abandon a fill while word 2 is outstanding, then prove the next fill restarts at word 0.
    rdy_max = 0; rv_max = 0;
    target = acc_cnt + 3;
    do_req(1'b0, 32'h3000, '0, 2 * WPL + 1, 1'b0);
    t = 0;
    while (acc_cnt < target) begin
      @(negedge clk); #1;
      if (++t > 200) begin fail("word2_wait_timeout"); $fatal(1, "word 2 never accepted"); end
    end
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    wq.delete(); rq.delete(); hs_q.delete();
    req_hs_n = rsp_hs_n;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 32'h3000, '0, 2 * WPL + 1, 1'b0);
    wait_idle();

`ifdef MEMCTRL_TIMEOUT_EN
    stall_all = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 32'h5040, '0, 0, 1'b1);
    wait_idle();
    stall_all = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_req(1'b0, 32'h5040, '0, 2 * WPL + 1, 1'b0);
    wait_idle();
`endif

    chk("scoreboard_drained", LW'(wq.size() + rq.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
